// File: rtl/core_seq_pkg.sv
// Shared types and defaults for the core run sequencer.
// Holds the sequencer state encoding and default run constants.
package core_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    RUN,
    DONE,
    FAULT
  } seq_state_t;

  localparam int DONE_PC_DEF    = 183;
  localparam int RST_CYCLES_DEF = 2;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Grants the data-memory port to the host while the core is parked.
// host_gnt doubles as the dmem port-select mux control.
module dmem_port_arbiter (
  input  logic clk,
  input  logic reset,
  input  logic host_req,
  input  logic port_free,
  output logic host_gnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      host_gnt <= 1'b0;
    end else begin
      host_gnt <= host_req && port_free;
    end
  end

endmodule

// File: rtl/core_run_sequencer.sv
// Core run sequencer: reset/release/completion watch plus dmem arbitration.
// Define SEQ_WATCHDOG_EN to enable the RUN-cycle watchdog and FAULT state.
module core_run_sequencer
  import core_seq_pkg::*;
#(
  parameter int PC_W       = 12,
  parameter int DONE_PC    = DONE_PC_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             host_req,
  output logic             host_gnt,
  output logic             core_reset,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  seq_state_t    state;
  logic          start_pending;
  logic [RW-1:0] rst_cnt;
  logic          launch;
  logic          port_free;
  logic          at_done;
  logic          wd_hit;

  assign port_free = (state == IDLE) || (state == DONE)
                  || (state == FAULT);
  assign launch    = start_pending && !host_gnt && !host_req;
  assign at_done   = (pc_in == PC_W'(DONE_PC));

`ifdef SEQ_WATCHDOG_EN
  assign wd_hit = (cycle_count == CNT_W'(MAX_CYCLES - 1));
`else
  logic unused_max;
  assign wd_hit     = 1'b0;
  assign unused_max = (MAX_CYCLES > 0);
`endif

  dmem_port_arbiter u_arb (
    .clk       (clk),
    .reset     (reset),
    .host_req  (host_req),
    .port_free (port_free),
    .host_gnt  (host_gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      core_reset    <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      cycle_count   <= '0;
      start_pending <= 1'b0;
      rst_cnt       <= '0;
    end else begin
      unique case (state)
        IDLE, DONE, FAULT: begin
          if (launch) begin
            state         <= RST;
            busy          <= 1'b1;
            rst_cnt       <= RW'(RST_CYCLES - 1);
            cycle_count   <= '0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            start_pending <= 1'b0;
          end else if (start) begin
            start_pending <= 1'b1;
          end
        end
        RST: begin
          if (rst_cnt == '0) begin
            state      <= RUN;
            core_reset <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        RUN: begin
          if (!(&cycle_count)) begin
            cycle_count <= cycle_count + 1'b1;
          end
          // Completion outranks a watchdog expiry in the same cycle
          if (at_done) begin
            state      <= DONE;
            done       <= 1'b1;
            core_reset <= 1'b1;
            busy       <= 1'b0;
          end else if (wd_hit) begin
            state      <= FAULT;
            timeout    <= 1'b1;
            core_reset <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          core_reset <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_run_sequencer.sv
// Randomized self-checking bench for core_run_sequencer.
// Drives a simple core PC model and checks runs against an outcome model.
module tb_core_run_sequencer;

  localparam int PC_W = 12;
  localparam int DPC  = 183;
  localparam int RSTC = 2;
  localparam int CW   = 8;
`ifdef SEQ_WATCHDOG_EN
  localparam int MAXC = 50;
  localparam bit WD   = 1'b1;
`else
  localparam int MAXC = 100000;
  localparam bit WD   = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            host_req;
  logic [PC_W-1:0] pc_in;
  logic            host_gnt;
  logic            core_reset;
  logic            busy;
  logic            done;
  logic            timeout;
  logic [CW-1:0]   cycle_count;

  int vectors = 0;
  int errors  = 0;
  int tgt     = 0;
  int rc      = 0;

  always #5 clk = ~clk;

  core_run_sequencer #(
    .PC_W       (PC_W),
    .DONE_PC    (DPC),
    .RST_CYCLES (RSTC),
    .CNT_W      (CW),
    .MAX_CYCLES (MAXC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pc_in       (pc_in),
    .host_req    (host_req),
    .host_gnt    (host_gnt),
    .core_reset  (core_reset),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  // Core model: PC restarts at 0 after reset, hits DONE_PC on RUN cycle tgt
  always @(posedge clk) rc <= core_reset ? 0 : rc + 1;
  assign pc_in = (tgt != 0 && rc == tgt - 1) ? PC_W'(DPC)
               : (rc < DPC ? PC_W'(rc) : '0);

  function automatic void expect_run(input int t, output int len,
                                     output bit d, output bit to);
    if (t != 0 && (!WD || t <= MAXC)) begin
      len = t; d = 1'b1; to = 1'b0;
    end else begin
      len = MAXC; d = 1'b0; to = 1'b1;
    end
  endfunction

  function automatic int sat(input int n);
    int lim;
    lim = (1 << CW) - 1;
    return (n > lim) ? lim : n;
  endfunction

  // Observes one run; may inject host_req, start or reset at RUN cycles
  task automatic measure_run(input int req_at, input int start_at,
                             input int rst_at, output int wait_b,
                             output int rst_len, output int run_len,
                             output bit gnt_seen, output bit ok);
    wait_b = 0; rst_len = 0; run_len = 0; gnt_seen = 0; ok = 1;
    do begin
      @(negedge clk);
      start = 1'b0;
      wait_b++;
    end while (!busy && wait_b < 50);
    if (!busy) begin
      ok = 0;
      return;
    end
    for (int i = 0; i < 2000 && busy; i++) begin
      if (host_gnt) gnt_seen = 1;
      if (core_reset) begin
        rst_len++;
      end else begin
        run_len++;
        if (run_len == req_at) host_req = 1'b1;
        start = (run_len == start_at);
        if (run_len == rst_at) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          return;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (busy) ok = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; host_req = 1'b0; tgt = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({core_reset, busy, done, timeout, host_gnt} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 10000",
               {core_reset, busy, done, timeout, host_gnt});
    end
    vectors++;
    if (cycle_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", cycle_count);
    end
  endtask

  task automatic test_basic();
    int wb, rl, nl, el; bit gs, ok, ed, eto;
    tgt = 184;
    expect_run(tgt, el, ed, eto);
    repeat (5) @(negedge clk);
    start = 1'b1;
    measure_run(0, 0, 0, wb, rl, nl, gs, ok);
    vectors++;
    if (!ok || wb != 2 || rl != RSTC) begin
      errors++;
      $display("FAIL basic_launch: ok=%0d wait=%0d rst=%0d want 1/2/%0d",
               ok, wb, rl, RSTC);
    end
    vectors++;
    if (nl != el) begin
      errors++;
      $display("FAIL basic_runlen: got %0d want %0d", nl, el);
    end
    vectors++;
    if ({done, timeout, core_reset, busy} !== {ed, eto, 2'b10}) begin
      errors++;
      $display("FAIL basic_flags: got %b want %b",
               {done, timeout, core_reset, busy}, {ed, eto, 2'b10});
    end
    vectors++;
    if (int'(cycle_count) != sat(el)) begin
      errors++;
      $display("FAIL basic_count: got %0d want %0d", cycle_count, sat(el));
    end
  endtask

  task automatic test_host_block();
    int wb, rl, nl, el, bad; bit gs, ok, ed, eto;
    tgt = 40;
    expect_run(tgt, el, ed, eto);
    host_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (host_gnt !== 1'b1) begin
      errors++;
      $display("FAIL host_grant: got %b want 1", host_gnt);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    repeat (9) begin
      @(negedge clk);
      if (busy || !host_gnt) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL host_hold: got %0d bad cycles want 0", bad);
    end
    host_req = 1'b0;
    measure_run(0, 0, 0, wb, rl, nl, gs, ok);
    vectors++;
    if (!ok || wb != 2 || nl != el) begin
      errors++;
      $display("FAIL host_release: ok=%0d wait=%0d len=%0d want 1/2/%0d",
               ok, wb, nl, el);
    end
    vectors++;
    if (done !== ed) begin
      errors++;
      $display("FAIL host_done: got %b want %b", done, ed);
    end
  endtask

  task automatic test_host_during_run();
    int wb, rl, nl, el; bit gs, ok, ed, eto;
    tgt = 100;
    expect_run(tgt, el, ed, eto);
    start = 1'b1;
    measure_run(20, 0, 0, wb, rl, nl, gs, ok);
    vectors++;
    if (!ok || gs || host_gnt !== 1'b0) begin
      errors++;
      $display("FAIL hrun_no_grant: ok=%0d seen=%0d gnt=%b want 1/0/0",
               ok, gs, host_gnt);
    end
    vectors++;
    if (nl != el || done !== ed || timeout !== eto) begin
      errors++;
      $display("FAIL hrun_result: len=%0d d=%b t=%b want %0d/%b/%b",
               nl, done, timeout, el, ed, eto);
    end
    @(negedge clk);
    vectors++;
    if (host_gnt !== 1'b1) begin
      errors++;
      $display("FAIL hrun_late_grant: got %b want 1", host_gnt);
    end
    host_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (host_gnt !== 1'b0) begin
      errors++;
      $display("FAIL hrun_release: got %b want 0", host_gnt);
    end
  endtask

  task automatic test_ignored_restart();
    int wb, rl, nl, el, bad; bit gs, ok, ed, eto;
    tgt = 40;
    expect_run(tgt, el, ed, eto);
    start = 1'b1;
    measure_run(0, 10, 0, wb, rl, nl, gs, ok);
    vectors++;
    if (!ok || nl != el || done !== ed) begin
      errors++;
      $display("FAIL restart_run: ok=%0d len=%0d d=%b want 1/%0d/%b",
               ok, nl, done, el, ed);
    end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL restart_pending: got %0d busy cycles want 0", bad);
    end
  endtask

  task automatic test_mid_reset();
    int wb, rl, nl, el; bit gs, ok, ed, eto;
    tgt = 200;
    start = 1'b1;
    measure_run(0, 0, 30, wb, rl, nl, gs, ok);
    vectors++;
    if ({core_reset, busy, done, timeout} !== 4'b1000
        || cycle_count !== '0) begin
      errors++;
      $display("FAIL midrst_state: flags=%b cnt=%0d want 1000/0",
               {core_reset, busy, done, timeout}, cycle_count);
    end
    tgt = 25;
    expect_run(tgt, el, ed, eto);
    start = 1'b1;
    measure_run(0, 0, 0, wb, rl, nl, gs, ok);
    vectors++;
    if (!ok || wb != 2 || rl != RSTC || nl != el
        || int'(cycle_count) != sat(el) || done !== ed) begin
      errors++;
      $display("FAIL midrst_rerun: wait=%0d rst=%0d len=%0d cnt=%0d want 2/%0d/%0d/%0d",
               wb, rl, nl, cycle_count, RSTC, el, sat(el));
    end
  endtask

`ifdef SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    int wb, rl, nl, el; bit gs, ok, ed, eto;
    for (int k = 0; k < 2; k++) begin
      tgt = (k == 0) ? 0 : MAXC;
      expect_run(tgt, el, ed, eto);
      start = 1'b1;
      measure_run(0, 0, 0, wb, rl, nl, gs, ok);
      vectors++;
      if (!ok || nl != el || int'(cycle_count) != sat(el)
          || done !== ed || timeout !== eto) begin
        errors++;
        $display("FAIL watchdog_%0d: len=%0d cnt=%0d d=%b t=%b want %0d/%0d/%b/%b",
                 k, nl, cycle_count, done, timeout, el, sat(el), ed, eto);
      end
    end
  endtask
`endif

  task automatic test_random();
    int wb, rl, nl, el, req_at, st_at; bit gs, ok, ed, eto;
    for (int n = 0; n < 10; n++) begin
      tgt    = WD ? int'($urandom_range(0, 70)) : int'($urandom_range(1, 300));
      req_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : 0;
      st_at  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : 0;
      expect_run(tgt, el, ed, eto);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      start = 1'b1;
      measure_run(req_at, st_at, 0, wb, rl, nl, gs, ok);
      vectors++;
      if (!ok || wb != 2 || rl != RSTC || gs) begin
        errors++;
        $display("FAIL rand%0d_seq: ok=%0d wait=%0d rst=%0d gnt=%0d",
                 n, ok, wb, rl, gs);
      end
      vectors++;
      if (nl != el || int'(cycle_count) != sat(el)) begin
        errors++;
        $display("FAIL rand%0d_count: len=%0d cnt=%0d want %0d/%0d",
                 n, nl, cycle_count, el, sat(el));
      end
      vectors++;
      if ({done, timeout, core_reset} !== {ed, eto, 1'b1}) begin
        errors++;
        $display("FAIL rand%0d_flags: got %b want %b", n,
                 {done, timeout, core_reset}, {ed, eto, 1'b1});
      end
      host_req = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || host_gnt !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_quiet: busy=%b gnt=%b want 0/0",
                 n, busy, host_gnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_host_block();
    test_host_during_run();
    test_ignored_restart();
    test_mid_reset();
`ifdef SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
